// File: rtl/alu_muldiv_seq.sv
// Iterative multiply / divide / remainder unit (shift-add multiplier, restoring divider).
// Optional macro ALU_MULDIV_SIGNED_EN selects two's complement DIV/REM and the ng flag.
module alu_muldiv_seq #(
    parameter int XLEN = 32,
    parameter int CW   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      ALUFn,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] out,
    output logic            zero,
    output logic            ng,
    output logic            div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_DIV  = 2'd1,
        OP_REM  = 2'd2,
        OP_NONE = 2'd3
    } op_t;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? ({XLEN{1'b0}} - v) : v;
    endfunction

    state_t          state_r, state_nxt;
    op_t             op_r, op_nxt, req_op_s;
    logic [CW-1:0]   cnt_r, cnt_nxt;
    // acc holds the product or the partial remainder; mcand holds the
    // multiplicand or divisor; mplier holds the multiplier or dividend/quotient.
    logic [XLEN-1:0] acc_r, acc_nxt;
    logic [XLEN-1:0] mcand_r, mcand_nxt;
    logic [XLEN-1:0] mplier_r, mplier_nxt;
    logic            negq_r, negq_nxt;
    logic            negr_r, negr_nxt;
    logic            x_neg_s, y_neg_s;
    logic [XLEN:0]   rem_w_s;
    logic [XLEN-1:0] rem_sub_s;
    logic            fin_load_s;
    logic [XLEN-1:0] fin_val_s;
    logic            fin_dbz_s;
    logic            fin_ng_s;

`ifdef ALU_MULDIV_SIGNED_EN
    assign x_neg_s  = x[XLEN-1];
    assign y_neg_s  = y[XLEN-1];
    assign fin_ng_s = fin_val_s[XLEN-1];
`else
    assign x_neg_s  = 1'b0;
    assign y_neg_s  = 1'b0;
    assign fin_ng_s = 1'b0;
`endif

    assign rem_w_s   = {acc_r, mplier_r[XLEN-1]};
    assign rem_sub_s = rem_w_s[XLEN-1:0] - mcand_r;

    // Decode the requested operation from the ALU function code.
    always_comb begin
        req_op_s = OP_NONE;
        case (ALUFn)
            4'b0101: req_op_s = OP_MUL;
            4'b0111: req_op_s = OP_DIV;
            4'b1001: req_op_s = OP_REM;
            default: req_op_s = OP_NONE;
        endcase
    end

    // Next-state and datapath step logic; fin_load marks the edge entering FIN.
    always_comb begin
        state_nxt  = state_r;
        op_nxt     = op_r;
        cnt_nxt    = cnt_r;
        acc_nxt    = acc_r;
        mcand_nxt  = mcand_r;
        mplier_nxt = mplier_r;
        negq_nxt   = negq_r;
        negr_nxt   = negr_r;
        fin_load_s = 1'b0;
        fin_val_s  = {XLEN{1'b0}};
        fin_dbz_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && (req_op_s != OP_NONE)) begin
                    op_nxt   = req_op_s;
                    cnt_nxt  = {CW{1'b0}};
                    acc_nxt  = {XLEN{1'b0}};
                    negq_nxt = x_neg_s ^ y_neg_s;
                    negr_nxt = x_neg_s;
                    if (req_op_s == OP_MUL) begin
                        mcand_nxt  = x;
                        mplier_nxt = y;
                        state_nxt  = S_MUL;
                    end else if (y == {XLEN{1'b0}}) begin
                        // Divide by zero skips the iterations entirely.
                        mcand_nxt  = y;
                        mplier_nxt = x;
                        state_nxt  = S_FIN;
                        fin_load_s = 1'b1;
                        fin_val_s  = (req_op_s == OP_DIV) ? {XLEN{1'b1}} : x;
                        fin_dbz_s  = 1'b1;
                    end else begin
                        mcand_nxt  = neg_if(y, y_neg_s);
                        mplier_nxt = neg_if(x, x_neg_s);
                        state_nxt  = S_DIV;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_MUL: begin
                if (mplier_r[0]) begin
                    acc_nxt = acc_r + mcand_r;
                end else begin
                    acc_nxt = acc_r;
                end
                mcand_nxt  = {mcand_r[XLEN-2:0], 1'b0};
                mplier_nxt = {1'b0, mplier_r[XLEN-1:1]};
                cnt_nxt    = cnt_r + CW'(1);
                if (cnt_r == CW'(XLEN - 1)) begin
                    state_nxt  = S_FIN;
                    fin_load_s = 1'b1;
                    fin_val_s  = acc_nxt;
                end else begin
                    state_nxt = S_MUL;
                end
            end
            S_DIV: begin
                if (rem_w_s >= {1'b0, mcand_r}) begin
                    acc_nxt    = rem_sub_s;
                    mplier_nxt = {mplier_r[XLEN-2:0], 1'b1};
                end else begin
                    acc_nxt    = rem_w_s[XLEN-1:0];
                    mplier_nxt = {mplier_r[XLEN-2:0], 1'b0};
                end
                cnt_nxt = cnt_r + CW'(1);
                if (cnt_r == CW'(XLEN - 1)) begin
                    state_nxt  = S_FIN;
                    fin_load_s = 1'b1;
                    fin_val_s  = (op_r == OP_DIV) ? neg_if(mplier_nxt, negq_r)
                                                  : neg_if(acc_nxt, negr_r);
                end else begin
                    state_nxt = S_DIV;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, working registers and registered result/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            op_r        <= OP_MUL;
            cnt_r       <= {CW{1'b0}};
            acc_r       <= {XLEN{1'b0}};
            mcand_r     <= {XLEN{1'b0}};
            mplier_r    <= {XLEN{1'b0}};
            negq_r      <= 1'b0;
            negr_r      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            out         <= {XLEN{1'b0}};
            zero        <= 1'b0;
            ng          <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            op_r     <= op_nxt;
            cnt_r    <= cnt_nxt;
            acc_r    <= acc_nxt;
            mcand_r  <= mcand_nxt;
            mplier_r <= mplier_nxt;
            negq_r   <= negq_nxt;
            negr_r   <= negr_nxt;
            busy     <= (state_nxt != S_IDLE);
            done     <= (state_nxt == S_FIN);
            if (fin_load_s) begin
                out         <= fin_val_s;
                zero        <= (fin_val_s == {XLEN{1'b0}});
                ng          <= fin_ng_s;
                div_by_zero <= fin_dbz_s;
            end else begin
                out         <= out;
                zero        <= zero;
                ng          <= ng;
                div_by_zero <= div_by_zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed cases plus random ops against an arithmetic model.
`timescale 1ns/1ps
module tb_alu_muldiv_seq;
    localparam int XLEN = 32;
    localparam logic [3:0] F_MUL = 4'b0101;
    localparam logic [3:0] F_DIV = 4'b0111;
    localparam logic [3:0] F_REM = 4'b1001;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [3:0]      ALUFn;
    logic [XLEN-1:0] x, y;
    logic            busy, done, zero, ng, div_by_zero;
    logic [XLEN-1:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.XLEN(XLEN), .CW(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUFn(ALUFn), .x(x), .y(y),
        .busy(busy), .done(done), .out(out), .zero(zero), .ng(ng),
        .div_by_zero(div_by_zero)
    );

    function automatic logic [XLEN-1:0] model(input logic [3:0] fn, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        if (fn == F_MUL) begin
            r = a * b;
        end else if (b == 32'h0) begin
            r = (fn == F_DIV) ? 32'hFFFF_FFFF : a;
        end else begin
`ifdef ALU_MULDIV_SIGNED_EN
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                r = (fn == F_DIV) ? 32'h8000_0000 : 32'h0;
            else
                r = (fn == F_DIV) ? ($signed(a) / $signed(b)) : ($signed(a) % $signed(b));
`else
            r = (fn == F_DIV) ? (a / b) : (a % b);
`endif
        end
        return r;
    endfunction

    function automatic logic exp_ng(input logic [XLEN-1:0] v);
`ifdef ALU_MULDIV_SIGNED_EN
        return v[XLEN-1];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [XLEN-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom());
        endcase
    endfunction

    // Issues one op (caller is at a negedge) and reports what was observed; no checking here.
    task automatic issue_op(input logic [3:0] fn, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input int inj, output int lat, output logic [XLEN-1:0] r,
                            output logic [2:0] flags, output logic hs_ok);
        logic busy_gap;
        start = 1'b1; ALUFn = fn; x = a; y = b;
        @(posedge clk); #1;
        start = 1'b0; ALUFn = 4'($urandom()); x = $urandom(); y = $urandom();
        lat = 0; busy_gap = 1'b0;
        while (lat < 200) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (inj != 0 && lat == inj) begin
                start = 1'b1; ALUFn = F_DIV; x = 32'd8; y = 32'd2;
            end
            if (done) break;
            if (!busy) busy_gap = 1'b1;
        end
        r = out;
        flags = {zero, ng, div_by_zero};
        busy_gap = busy_gap | !busy;
        @(negedge clk);
        hs_ok = !busy_gap && !done && !busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ALUFn = 4'h0; x = 32'h0; y = 32'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, out, zero, ng, div_by_zero} !== {(XLEN + 5){1'b0}}) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b out=%h z=%b ng=%b dbz=%b, required all 0",
                     busy, done, out, zero, ng, div_by_zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [3:0]      fns [12];
        logic [XLEN-1:0] as [12], bs [12], exps [12];
        int              n, lat, elat;
        logic [XLEN-1:0] r;
        logic [2:0]      fl, efl;
        logic            hs;
        fns[0] = F_MUL; as[0] = 32'd7;          bs[0] = 32'd6;          exps[0] = 32'd42;
        fns[1] = F_MUL; as[1] = 32'hFFFF_FFFF;  bs[1] = 32'd2;          exps[1] = 32'hFFFF_FFFE;
        fns[2] = F_DIV; as[2] = 32'd100;        bs[2] = 32'd7;          exps[2] = 32'd14;
        fns[3] = F_REM; as[3] = 32'd100;        bs[3] = 32'd7;          exps[3] = 32'd2;
        fns[4] = F_DIV; as[4] = 32'd5;          bs[4] = 32'd0;          exps[4] = 32'hFFFF_FFFF;
        fns[5] = F_REM; as[5] = 32'd5;          bs[5] = 32'd0;          exps[5] = 32'd5;
        fns[6] = F_DIV; as[6] = 32'd9;          bs[6] = 32'd3;          exps[6] = 32'd3;
        n = 7;
`ifdef ALU_MULDIV_SIGNED_EN
        fns[7]  = F_DIV; as[7]  = 32'hFFFF_FFF9; bs[7]  = 32'd2;         exps[7]  = 32'hFFFF_FFFD;
        fns[8]  = F_REM; as[8]  = 32'hFFFF_FFF9; bs[8]  = 32'd2;         exps[8]  = 32'hFFFF_FFFF;
        fns[9]  = F_DIV; as[9]  = 32'h8000_0000; bs[9]  = 32'hFFFF_FFFF; exps[9]  = 32'h8000_0000;
        fns[10] = F_REM; as[10] = 32'h8000_0000; bs[10] = 32'hFFFF_FFFF; exps[10] = 32'h0;
        fns[11] = F_MUL; as[11] = 32'hFFFF_FFFD; bs[11] = 32'd4;         exps[11] = 32'hFFFF_FFF4;
        n = 12;
`endif
        for (int i = 0; i < n; i++) begin
            issue_op(fns[i], as[i], bs[i], 0, lat, r, fl, hs);
            elat = (fns[i] != F_MUL && bs[i] == 32'h0) ? 1 : 33;
            efl  = {exps[i] == 32'h0, exp_ng(exps[i]), (fns[i] != F_MUL && bs[i] == 32'h0)};
            n_checks++;
            if (r !== exps[i]) begin
                n_fail++; $display("FAIL directed_out[%0d]: got %h required %h", i, r, exps[i]);
            end
            n_checks++;
            if (lat !== elat) begin
                n_fail++; $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, elat);
            end
            n_checks++;
            if (fl !== efl) begin
                n_fail++; $display("FAIL directed_flags[%0d] zng_dbz: got %b required %b", i, fl, efl);
            end
            n_checks++;
            if (hs !== 1'b1) begin
                n_fail++; $display("FAIL directed_handshake[%0d]: got %b required 1", i, hs);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int              lat;
        logic [XLEN-1:0] r;
        logic [2:0]      fl;
        logic            hs, seen;
        issue_op(F_MUL, 32'd3, 32'd3, 10, lat, r, fl, hs);
        n_checks++;
        if (r !== 32'd9 || lat !== 33 || hs !== 1'b1) begin
            n_fail++; $display("FAIL busy_ignore: got out=%h lat=%0d hs=%b required out=9 lat=33 hs=1", r, lat, hs);
        end
        start = 1'b1; ALUFn = 4'b0010; x = 32'd1; y = 32'd1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            seen = seen | busy | done;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL illegal_op: busy/done got %b required 0", seen);
        end
    endtask

    task automatic test_reset_abort();
        int              lat;
        logic [XLEN-1:0] r;
        logic [2:0]      fl;
        logic            hs, seen;
        start = 1'b1; ALUFn = F_DIV; x = 32'd1000; y = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, out} !== {(XLEN + 2){1'b0}}) begin
            n_fail++; $display("FAIL reset_abort: got busy=%b done=%b out=%h required 0 0 0", busy, done, out);
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | done | busy;
        end
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            seen = seen | done | busy;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_done: busy/done got %b required 0", seen);
        end
        issue_op(F_MUL, 32'd4, 32'd5, 0, lat, r, fl, hs);
        n_checks++;
        if (r !== 32'd20 || lat !== 33 || hs !== 1'b1) begin
            n_fail++; $display("FAIL after_reset_mul: got out=%h lat=%0d hs=%b required out=14 lat=33 hs=1", r, lat, hs);
        end
    endtask

    task automatic test_random();
        logic [3:0]      fn;
        logic [XLEN-1:0] a, b, e, r;
        logic [2:0]      fl, efl;
        int              lat, elat;
        logic            hs;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: fn = F_MUL;
                1: fn = F_DIV;
                default: fn = F_REM;
            endcase
            a = pick(); b = pick();
            issue_op(fn, a, b, 0, lat, r, fl, hs);
            e    = model(fn, a, b);
            elat = (fn != F_MUL && b == 32'h0) ? 1 : 33;
            efl  = {e == 32'h0, exp_ng(e), (fn != F_MUL && b == 32'h0)};
            n_checks++;
            if (r !== e) begin
                n_fail++; $display("FAIL random_out fn=%b x=%h y=%h: got %h required %h", fn, a, b, r, e);
            end
            n_checks++;
            if (lat !== elat || fl !== efl || hs !== 1'b1) begin
                n_fail++;
                $display("FAIL random_ctl fn=%b x=%h y=%h: got lat=%0d flags=%b hs=%b required lat=%0d flags=%b hs=1",
                         fn, a, b, lat, fl, hs, elat, efl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
